// File: rtl/adder_pkg.sv
// adder_pkg: shared width, FSM encoding and index-width helper for the adder arbiter
package adder_pkg;
    localparam int ADD_W = 32;
    typedef enum logic [1:0] {IDLE = 2'b00, ADD = 2'b01, RESP = 2'b10} state_t;
    function automatic int idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/adder_arbiter_if.sv
// adder_arbiter_if: request/response bundle between requesters and the shared adder
interface adder_arbiter_if #(parameter int NREQ = 4, parameter int W = 32, parameter int IDW = 2);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [W-1:0]      rsp_sum;
    logic [IDW-1:0]    rsp_id;
    logic              busy;
    modport slave (input req_valid, req_a, req_b, rsp_ready, output req_ready, rsp_valid, rsp_sum, rsp_id, busy);
    modport master (output req_valid, req_a, req_b, rsp_ready, input req_ready, rsp_valid, rsp_sum, rsp_id, busy);
endinterface

// File: rtl/add.sv
// add: 32-bit ripple-carry adder, carry-out not exported
module add (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_s
);
    logic [31:0] w_c;
    assign w_c[0] = 1'b0;
    for (genvar i = 0; i < 32; i++) begin : g_bit
        assign o_s[i] = i_a[i] ^ i_b[i] ^ w_c[i];
        if (i < 31) begin : g_c
            assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
    end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, searches upward from the pointer with wrap
module rr_arbiter #(parameter int N = 4, parameter int IW = 2) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);
    // first requester at or after the pointer wins
    always_comb begin
        logic found;
        int   j;
        o_gnt = '0;
        o_idx = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(i_ptr) + k) % N;
            if (!found && i_req[j]) begin
                found    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IW'(j);
            end
        end
    end
endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one registered-in/registered-out ripple adder
module adder_arbiter
    import adder_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = ADD_W,
    parameter int IDW  = idw(NREQ)
) (
    input logic            clk,
    input logic            rst_n,
    adder_arbiter_if.slave bus
);
    state_t         r_state, w_next;
    logic [W-1:0]   r_op_a, r_op_b, r_sum, w_sum;
    logic [IDW-1:0] r_ptr, r_id, w_idx;
    logic [NREQ-1:0] w_gnt;
    logic           w_hs;

    rr_arbiter #(.N(NREQ), .IW(IDW)) u_rr (.i_req(bus.req_valid), .i_ptr(r_ptr), .o_gnt(w_gnt), .o_idx(w_idx));
    add u_add (.i_a(r_op_a), .i_b(r_op_b), .o_s(w_sum));

    assign bus.req_ready = (r_state == IDLE) ? w_gnt : '0;
    assign w_hs          = |(bus.req_valid & bus.req_ready);
    assign bus.rsp_valid = (r_state == RESP) ? ({{(NREQ-1){1'b0}}, 1'b1} << r_id) : '0;
    assign bus.rsp_sum   = r_sum;
    assign bus.rsp_id    = r_id;
    assign bus.busy      = r_state != IDLE;

    // next state: accept, add for one cycle, hold result until its owner takes it
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && w_hs) w_next = ADD;
        else if (r_state == ADD) w_next = RESP;
        else if (r_state == RESP && bus.rsp_ready[r_id]) w_next = IDLE;
    end

    // state, operand capture on grant, result capture after the add cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_sum   <= '0;
            r_id    <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_next;
            if (w_hs) begin
                r_op_a <= bus.req_a[w_idx*W +: W];
                r_op_b <= bus.req_b[w_idx*W +: W];
                r_id   <= w_idx;
                r_ptr  <= (w_idx == IDW'(NREQ-1)) ? '0 : w_idx + 1'b1;
            end
            if (r_state == ADD) r_sum <= w_sum;
        end
    end
endmodule
